// File: rtl/conv_column_mac.sv
// Streaming 3x3 convolution window MAC: accepts three pixel columns, pairs each with
// the weights fetched one cycle later by cnt, and emits the signed 20-bit window sum.
module conv_column_mac (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [23:0] pix_col,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [1:0]  cnt,
    input  logic [7:0]  w0,
    input  logic [7:0]  w1,
    input  logic [7:0]  w2,
    output logic [19:0] result,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_e;

    state_e             state_q;
    logic [1:0]         cnt_q;
    logic [23:0]        pix_q;
    logic               s1_valid_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic signed [19:0] acc_q;
    logic signed [19:0] result_q;

    // Pixels are zero-extended and weights sign-extended to 17 bits so every
    // product is exact in 17-bit signed arithmetic.
    logic signed [16:0] px0, px1, px2;
    logic signed [16:0] wx0, wx1, wx2;
    logic signed [16:0] prod0, prod1, prod2;
    logic signed [19:0] col_sum;
    logic signed [19:0] acc_d;

    assign px0 = {9'd0, pix_q[7:0]};
    assign px1 = {9'd0, pix_q[15:8]};
    assign px2 = {9'd0, pix_q[23:16]};
    assign wx0 = {{9{w0[7]}}, w0};
    assign wx1 = {{9{w1[7]}}, w1};
    assign wx2 = {{9{w2[7]}}, w2};

    assign prod0   = px0 * wx0;
    assign prod1   = px1 * wx1;
    assign prod2   = px2 * wx2;
    assign col_sum = {{3{prod0[16]}}, prod0} + {{3{prod1[16]}}, prod1} + {{3{prod2[16]}}, prod2};
    assign acc_d   = acc_q + col_sum;

    // NOTE: all state below updates with non-blocking assignments so every branch
    // reads the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            pix_q       <= 24'd0;
            s1_valid_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= 20'sd0;
            result_q    <= 20'sd0;
        end else if (abort) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            s1_valid_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= 20'sd0;
        end else begin
            s1_valid_q <= 1'b0;
            if (s1_valid_q) begin
                acc_q <= acc_d;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (in_valid && in_ready_q) begin
                        pix_q      <= pix_col;
                        s1_valid_q <= 1'b1;
                        if (cnt_q == 2'd2) begin
                            cnt_q      <= 2'd0;
                            state_q    <= WAIT;
                            in_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                WAIT: begin
                    // Column 2 is in pix_q and its weights have just arrived.
                    result_q    <= acc_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= 20'sd0;
                        if (start) begin
                            state_q    <= RUN;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign cnt       = cnt_q;
    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_conv_column_mac.sv
// Bench for conv_column_mac: a registered weight ROM addressed by cnt, a reference
// model feeding an expected-result queue, and one task per scenario.
module tb_conv_column_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [23:0] pix_col;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  cnt;
    logic [7:0]  w0, w1, w2;
    logic [19:0] result;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    logic signed [7:0]  rom [3][3];   // [column][row]
    logic signed [19:0] exp_q [$];

    conv_column_mac dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pix_col   (pix_col),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cnt       (cnt),
        .w0        (w0),
        .w1        (w1),
        .w2        (w2),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Filter address register: weights for cnt appear one edge after cnt is sampled.
    always @(posedge clk) begin
        w0 <= rom[cnt][0];
        w1 <= rom[cnt][1];
        w2 <= rom[cnt][2];
    end

    function automatic logic signed [19:0] model(input logic [23:0] c0, input logic [23:0] c1,
                                                 input logic [23:0] c2);
        logic [23:0] cols [3];
        int acc;
        cols[0] = c0;
        cols[1] = c1;
        cols[2] = c2;
        acc = 0;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                acc += int'(cols[c][8*r +: 8]) * int'(rom[c][r]);
        return 20'(acc);
    endfunction

    task automatic set_rom_const(input logic signed [7:0] v);
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                rom[c][r] = v;
    endtask

    task automatic set_rom_seq();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                rom[c][r] = 8'(3 * r + c + 1);
    endtask

    // Drives three columns starting in RUN; optionally records the expected sum.
    task automatic send_cols(input logic [23:0] c0, input logic [23:0] c1, input logic [23:0] c2,
                             input int gap, input bit push);
        logic [23:0] cols [3];
        cols[0] = c0;
        cols[1] = c1;
        cols[2] = c2;
        if (push) exp_q.push_back(model(c0, c1, c2));
        for (int i = 0; i < 3; i++) begin
            pix_col  = cols[i];
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            if (i < 2) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_window(input logic [23:0] c0, input logic [23:0] c1, input logic [23:0] c2,
                               input int gap, input bit push);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_cols(c0, c1, c2, gap, push);
    endtask

    task automatic wait_out(output logic [19:0] r, output bit got);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        got = (out_valid === 1'b1);
        r   = result;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b0 || cnt !== 2'd0 || out_valid !== 1'b0 || result !== 20'd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b cnt=%0d out_valid=%b result=%0d, expected all 0",
                     in_ready, cnt, out_valid, result);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || cnt !== 2'd0) begin
            errors++;
            $display("FAIL idle_after_reset: in_ready=%b cnt=%0d, expected 0 0", in_ready, cnt);
        end
    endtask

    task automatic test_basic();
        logic signed [19:0] exp;
        set_rom_const(8'sd1);
        send_window(24'h0a0a0a, 24'h0a0a0a, 24'h0a0a0a, 0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait_cycle4: out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || $signed(result) !== exp || exp !== 20'sd90) begin
            errors++;
            $display("FAIL basic_cycle5: out_valid=%b result=%0d, expected 1 %0d (90)",
                     out_valid, $signed(result), exp);
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_handshake: out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_extremes();
        logic [19:0] r;
        bit got;
        logic signed [19:0] exp;
        set_rom_const(8'sh80);
        send_window(24'hffffff, 24'hffffff, 24'hffffff, 0, 1'b1);
        wait_out(r, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || $signed(r) !== exp || exp !== -20'sd293760) begin
            errors++;
            $display("FAIL extreme_neg: got=%b result=%0d, expected %0d", got, $signed(r), exp);
        end
        release_out();
        set_rom_const(8'sd127);
        send_window(24'hffffff, 24'hffffff, 24'hffffff, 0, 1'b1);
        wait_out(r, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || $signed(r) !== exp || exp !== 20'sd291465) begin
            errors++;
            $display("FAIL extreme_pos: got=%b result=%0d, expected %0d", got, $signed(r), exp);
        end
        release_out();
    endtask

    task automatic test_order();
        logic [19:0] r;
        bit got;
        logic signed [19:0] exp;
        set_rom_seq();
        send_window(24'h010101, 24'h020202, 24'h030303, 0, 1'b1);
        wait_out(r, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || $signed(r) !== exp || exp !== 20'sd96) begin
            errors++;
            $display("FAIL column_order: got=%b result=%0d, expected %0d (96)", got, $signed(r), exp);
        end
        release_out();
        send_window(24'h030201, 24'h000000, 24'h0507ff, 0, 1'b1);
        wait_out(r, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || $signed(r) !== exp) begin
            errors++;
            $display("FAIL mixed_rows: got=%b result=%0d, expected %0d", got, $signed(r), exp);
        end
        release_out();
    endtask

    task automatic test_stall();
        logic [19:0] r;
        bit got;
        bit gap_bad;
        logic signed [19:0] exp;
        set_rom_const(8'sd1);
        exp_q.push_back(model(24'h0a0a0a, 24'h0a0a0a, 24'h0a0a0a));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gap_bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_col  = 24'h0a0a0a;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    if (cnt !== 2'(i + 1) || in_ready !== 1'b1) gap_bad = 1'b1;
                    @(negedge clk);
                end
            end
        end
        checks++;
        if (gap_bad) begin
            errors++;
            $display("FAIL stall_gaps: cnt/in_ready changed during gap (cnt=%0d in_ready=%b)", cnt, in_ready);
        end
        wait_out(r, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || $signed(r) !== exp || exp !== 20'sd90) begin
            errors++;
            $display("FAIL stall_result: got=%b result=%0d, expected %0d", got, $signed(r), exp);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [19:0] r;
        bit got;
        bit unstable;
        logic signed [19:0] exp;
        set_rom_seq();
        send_window(24'h030201, 24'h060504, 24'h090807, 0, 1'b1);
        wait_out(r, got);
        exp = exp_q.pop_front();
        unstable = !got;
        for (int k = 0; k < 4; k++) begin
            if (out_valid !== 1'b1 || $signed(result) !== exp || in_ready !== 1'b0) unstable = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL backpressure_hold: out_valid=%b result=%0d in_ready=%b, expected 1 %0d 0",
                     out_valid, $signed(result), in_ready, exp);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || cnt !== 2'd0) begin
            errors++;
            $display("FAIL handshake_restart: in_ready=%b out_valid=%b cnt=%0d, expected 1 0 0",
                     in_ready, out_valid, cnt);
        end
        send_cols(24'h010101, 24'h020202, 24'h030303, 0, 1'b1);
        wait_out(r, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || $signed(r) !== exp || exp !== 20'sd96) begin
            errors++;
            $display("FAIL restart_result: got=%b result=%0d, expected %0d", got, $signed(r), exp);
        end
        release_out();
    endtask

    task automatic test_abort();
        logic [19:0] r;
        bit got;
        bit saw_valid;
        logic signed [19:0] exp;
        set_rom_const(8'sd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pix_col  = 24'h646464;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        abort    = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (cnt !== 2'd0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: cnt=%0d in_ready=%b out_valid=%b, expected 0 0 0",
                     cnt, in_ready, out_valid);
        end
        saw_valid = 1'b0;
        repeat (6) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) saw_valid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL abort_idle: block left IDLE after abort (out_valid=%b in_ready=%b)",
                     out_valid, in_ready);
        end
        send_window(24'h0a0a0a, 24'h0a0a0a, 24'h0a0a0a, 0, 1'b1);
        wait_out(r, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || $signed(r) !== exp || exp !== 20'sd90) begin
            errors++;
            $display("FAIL abort_recovery: got=%b result=%0d, expected %0d", got, $signed(r), exp);
        end
        release_out();
    endtask

    task automatic test_reset_in_wait();
        logic [19:0] r;
        bit got;
        bit saw_valid;
        logic signed [19:0] exp;
        set_rom_const(8'sd2);
        send_window(24'h111111, 24'h222222, 24'h333333, 0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || cnt !== 2'd0 || out_valid !== 1'b0 || result !== 20'd0) begin
            errors++;
            $display("FAIL reset_in_wait: in_ready=%b cnt=%0d out_valid=%b result=%0d, expected all 0",
                     in_ready, cnt, out_valid, result);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (8) begin
            if (out_valid !== 1'b0) saw_valid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL reset_discard: out_valid asserted after reset in WAIT");
        end
        send_window(24'h010203, 24'h040506, 24'h070809, 0, 1'b1);
        wait_out(r, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || $signed(r) !== exp) begin
            errors++;
            $display("FAIL reset_recovery: got=%b result=%0d, expected %0d", got, $signed(r), exp);
        end
        release_out();
    endtask

    initial begin
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pix_col   = 24'd0;
        set_rom_const(8'sd0);
        test_reset();
        test_basic();
        test_extremes();
        test_order();
        test_stall();
        test_back_to_back();
        test_abort();
        test_reset_in_wait();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_column_mac.md
CONV_COLUMN_MAC -- requirements
Module: conv_column_mac

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new 3x3 window computation; sampled only in IDLE.
REQ-005 abort  input  1  synchronous abort; discards any window in progress.
REQ-006 pix_col  input  24  one window column: {row2, row1, row0}, each 8-bit unsigned.
REQ-007 in_valid  input  1  pix_col is valid.
REQ-008 in_ready  output  1  block accepts pix_col this cycle.
REQ-009 cnt  output  2  index (0..2) of the column being accepted; drives the filter address register.
REQ-010 w0, w1, w2  input  8 each  filter weights, rows 0/1/2 of column cnt; valid one cycle after cnt is sampled.
REQ-011 result  output  20  signed window sum.
REQ-012 out_valid  output  1  result is valid.
REQ-013 out_ready  input  1  consumer accepts result.

Function
REQ-014 The FSM SHALL have four states: IDLE, RUN, WAIT and DONE.
REQ-015 IDLE SHALL hold in_ready=0, cnt=0 and acc=0; start=1 moves the FSM to RUN.
REQ-016 RUN SHALL hold in_ready=1; on in_valid&&in_ready it latches pix_col into pix_q, sets s1_valid=1, and increments cnt.
- Gaps in in_valid stall without penalty.
REQ-017 In RUN, accepting with cnt==2 SHALL move the FSM to WAIT and return cnt to 0.
REQ-018 In any cycle with s1_valid=1, the block SHALL compute acc <= acc + pix_q.row0*w0 + pix_q.row1*w1 + pix_q.row2*w2; s1_valid otherwise clears to 0.
- This aligns each pixel column with weights addressed by cnt one edge earlier.
REQ-019 Arithmetic SHALL be as follows.
- Pixels are zero-extended to 9-bit signed; weights are 8-bit two's complement.
- Each product is 17-bit signed; acc and result are 20-bit signed.
- No saturation is applied; the full range is -293760..291465.
REQ-020 WAIT SHALL hold in_ready=0 and apply the final (column 2) MAC, writing result <= acc + final products and setting out_valid=1; the FSM then moves to DONE.
REQ-021 DONE SHALL hold result and out_valid stable until out_ready=1.
- On that handshake: out_valid clears, acc clears, and the FSM goes to IDLE.
- If start=1 in the same cycle, the FSM goes directly to RUN.
REQ-022 start SHALL be ignored in RUN, WAIT and DONE.
REQ-023 Latency with continuous in_valid SHALL be as follows: start at cycle 0 gives column acceptance at cycles 1, 2 and 3, WAIT at cycle 4, and out_valid at cycle 5.
REQ-024 abort=1 in any state SHALL take effect at the next edge.
- Next state is IDLE, with cnt=0, acc=0, s1_valid=0 and out_valid=0.
- abort has priority over start, in_valid and out_ready.
REQ-025 cnt SHALL never exceed 2.
- in_valid while in_ready=0 SHALL be ignored with no state change.

Reset
REQ-026 While rst=1, the following SHALL hold immediately (asynchronous):
- state=IDLE, cnt=0, acc=0, pix_q=0, s1_valid=0;
- result=0, out_valid=0, in_ready=0.
REQ-027 Deassertion of rst SHALL begin operation at the next rising clk edge.
- Reset during RUN, WAIT or DONE SHALL discard the partial window.

Verification
REQ-028 Basic sum: weights all 1, three columns of pixels all 10 -> result=90, out_valid at cycle 5 after start.
REQ-029 Negative extreme: weights all -128 (0x80), pixels all 255 -> result=-293760; positive extreme: weights 127, pixels 255 -> result=291465.
REQ-030 Column ordering: ROM holds 1..9 row-major (w for cnt=c is {c+7, c+4, c+1}); column c pixels {1,1,1}*(c+1) -> result = (12) + (15*2) + (18*3) = 96.
REQ-031 Stall: in_valid low for 2 cycles between each column, values as REQ-028.
- Expect result=90.
- cnt holds during the gaps.
- in_ready stays 1 in RUN.
REQ-032 Backpressure: hold out_ready=0 for 4 cycles.
- Expect result/out_valid stable and in_ready=0.
- Then out_ready=1 together with start=1 -> next cycle is RUN with acc=0.
REQ-033 Abort and reset mid-run:
- abort after 2 accepted columns -> IDLE and cnt=0, then a new window yields the correct value.
- rst pulse in WAIT -> out_valid never asserts, and all outputs are 0.
